// File: rtl/ifetch_unit_if.sv
// Bundle of fetch-stage signals: ROM read port, redirect request and the
// instruction stream towards decode. The fetch unit uses the master modport.
//
// Stream handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1. Once out_valid is 1 the head (out_inst/out_pc/out_oob)
// stays stable until it is transferred or a redirect flushes it; out_valid
// never depends on out_ready.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 10
`endif

interface ifetch_unit_if #(
    parameter int ADDR_WIDTH = `ROM_ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [31:0]           rom_data;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_inst;
    logic [31:0]           out_pc;
    logic                  out_oob;

    modport master (
        output rom_addr,
        input  rom_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output out_oob
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  out_oob
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads the async ROM, and buffers
// fetched words in a small prefetch FIFO presented as a valid/ready stream.
// Redirects flush the FIFO and restart fetch at the target address.
`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 10
`endif

module ifetch_unit #(
    parameter int          ADDR_WIDTH = `ROM_ADDR_WIDTH,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst_n,
    ifetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic [31:0]      pc_mem   [FIFO_DEPTH];
    logic [31:0]      inst_mem [FIFO_DEPTH];
    logic             oob_mem  [FIFO_DEPTH];

    // Last valid head, so outputs hold while the FIFO is empty.
    logic [31:0]      hold_pc;
    logic [31:0]      hold_inst;
    logic             hold_oob;

    logic             fetch_oob;
    logic [31:0]      fetch_inst;
    logic             head_valid;
    logic             pop;
    logic             push;
    logic             full;

    // ROM address and range check come straight from the PC.
    assign bus.rom_addr = pc[ADDR_WIDTH+1:2];
    assign fetch_oob    = |pc[31:ADDR_WIDTH+2];
    assign fetch_inst   = fetch_oob ? NOP_INST : bus.rom_data;

    assign head_valid = (count != '0);
    assign full       = (count == DEPTH_C);
    assign pop        = head_valid && bus.out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO keeps streaming.
    assign push       = !bus.redirect_valid && (!full || pop);

    // PC, pointers and occupancy; redirect overrides everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.redirect_valid) begin
            pc     <= bus.redirect_pc & 32'hFFFF_FFFC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: write the fetched entry at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
                oob_mem[i]  <= 1'b0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= pc;
            inst_mem[wr_ptr] <= fetch_inst;
            oob_mem[wr_ptr]  <= fetch_oob;
        end
    end

    // Track the current head so it can be replayed while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_pc   <= '0;
            hold_inst <= '0;
            hold_oob  <= 1'b0;
        end else if (head_valid) begin
            hold_pc   <= pc_mem[rd_ptr];
            hold_inst <= inst_mem[rd_ptr];
            hold_oob  <= oob_mem[rd_ptr];
        end
    end

    // Stream outputs come directly from the FIFO head.
    always_comb begin
        bus.out_valid = head_valid;
        bus.out_pc    = hold_pc;
        bus.out_inst  = hold_inst;
        bus.out_oob   = hold_oob;
        if (head_valid) begin
            bus.out_pc   = pc_mem[rd_ptr];
            bus.out_inst = inst_mem[rd_ptr];
            bus.out_oob  = oob_mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized stream, all
// checked every cycle against a queue-based model of the fetch stage.
module tb_ifetch_unit;
    localparam int          AW       = 10;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ROM_BYTES = 32'd4 << AW;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        oob;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_on = 1'b0;

    ent_t        exp_q[$];
    logic [31:0] m_pc;
    int          n_vec = 0;
    int          n_err = 0;

    ifetch_unit_if #(.ADDR_WIDTH(AW)) bus();

    ifetch_unit #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH),
        .NOP_INST  (NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // clock
    always #5 clk = ~clk;

    // ROM: word k holds 0x1000_0000 + k
    assign bus.rom_data = 32'h1000_0000 + 32'(bus.rom_addr);

    function automatic logic m_is_oob(input logic [31:0] a);
        return 64'(a) >= (64'd1 << (AW + 2));
    endfunction

    function automatic logic [31:0] m_rom(input logic [31:0] a);
        return 32'h1000_0000 + ((a / 4) % (32'd1 << AW));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge at transaction level.
    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        int   sz;
        logic pop;
        ent_t e;
        sz  = exp_q.size();
        pop = (sz != 0) && rdy;
        if (rv) begin
            exp_q.delete();
            m_pc = (rpc / 4) * 4;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (sz < DEPTH || pop) begin
                e.pc   = m_pc;
                e.oob  = m_is_oob(m_pc);
                e.inst = e.oob ? NOP : m_rom(m_pc);
                exp_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // driver: apply inputs for one cycle, advance model at the edge
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        @(posedge clk);
        if (rst_n) model_step(rv, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_pc = RESET_PC;
        #1;
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_pc",    bus.out_pc,         32'd0);
        chk("mrst_inst",  bus.out_inst,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'd0, 1'b1);
        chk("mrst_restart_valid", 32'(bus.out_valid), 32'd1);
        chk("mrst_restart_pc",    bus.out_pc,         RESET_PC);
    endtask

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("rom_addr", 32'(bus.rom_addr), (m_pc / 4) % (32'd1 << AW));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_pc",   bus.out_pc,        exp_q[0].pc);
                chk("out_inst", bus.out_inst,      exp_q[0].inst);
                chk("out_oob",  32'(bus.out_oob),  32'(exp_q[0].oob));
            end
        end
    end

    initial begin
        logic        rv;
        logic        rdy;
        logic [31:0] rpc;

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.out_ready      = 1'b0;
        m_pc   = RESET_PC;
        rst_n  = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // reset state
        chk("rst_valid",    32'(bus.out_valid), 32'd0);
        chk("rst_pc",       bus.out_pc,         32'd0);
        chk("rst_inst",     bus.out_inst,       32'd0);
        chk("rst_oob",      32'(bus.out_oob),   32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr),  32'd0);
        rst_n = 1'b1;

        // streaming with no bubbles
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 32'd0, 1'b1);
            chk("seq_valid", 32'(bus.out_valid), 32'd1);
            chk("seq_pc",    bus.out_pc,         32'(i * 4));
            chk("seq_inst",  bus.out_inst,       32'h1000_0000 + 32'(i));
        end

        // restart at 0, then stall for 5 cycles
        cycle(1'b1, 32'd0, 1'b0);
        chk("stall_flush_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b0);
        chk("stall_head_pc",  bus.out_pc,        32'd0);
        chk("stall_rom_addr", 32'(bus.rom_addr), 32'd2);
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 32'd0, 1'b1);
            chk("resume_pc", bus.out_pc, 32'(i * 4));
        end

        // redirect while full and popping
        cycle(1'b1, 32'h0000_0102, 1'b1);
        chk("redir_bubble", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
        chk("redir_valid", 32'(bus.out_valid), 32'd1);
        chk("redir_pc",    bus.out_pc,         32'h0000_0100);
        chk("redir_inst",  bus.out_inst,       32'h1000_0040);
        cycle(1'b0, 32'd0, 1'b1);
        chk("redir_next_pc", bus.out_pc, 32'h0000_0104);

        // just past the ROM
        cycle(1'b1, ROM_BYTES, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        chk("oob_flag", 32'(bus.out_oob), 32'd1);
        chk("oob_inst", bus.out_inst,     32'h0000_0013);
        cycle(1'b0, 32'd0, 1'b1);
        chk("oob_next_flag", 32'(bus.out_oob), 32'd1);
        chk("oob_next_pc",   bus.out_pc,       ROM_BYTES + 32'd4);

        // PC wrap
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        chk("wrap_pc",  bus.out_pc,       32'hFFFF_FFFC);
        chk("wrap_oob", 32'(bus.out_oob), 32'd1);
        cycle(1'b0, 32'd0, 1'b1);
        chk("wrap0_pc",   bus.out_pc,       32'h0000_0000);
        chk("wrap0_oob",  32'(bus.out_oob), 32'd0);
        chk("wrap0_inst", bus.out_inst,     32'h1000_0000);

        // back-to-back redirects: last one wins
        cycle(1'b1, 32'h0000_0200, 1'b1);
        cycle(1'b1, 32'h0000_0300, 1'b1);
        chk("b2b_bubble", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
        chk("b2b_pc",   bus.out_pc,   32'h0000_0300);
        chk("b2b_inst", bus.out_inst, 32'h1000_00C0);

        // randomized stream with one asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) mid_reset();
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       rpc = $urandom_range(0, int'(ROM_BYTES) - 1);
                1:       rpc = ROM_BYTES - 32'(4 * $urandom_range(0, 2));
                2:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: rpc = $urandom;
            endcase
            cycle(rv, rpc, rdy);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
